game_sequencer: RTL

Top-level game-flow controller for the countdown timer. Sequences the timer by driving its start, miss and clear inputs; tracks hits toward stage and game completion; converts timer expiry into a FAIL state. Sits between the button/game-logic front end and the timer/7-segment datapath on the 50 MHz board clock.

---
 rtl/game_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// game_sequencer: game-flow controller for the countdown timer.
// Drives the timer's start/miss/clear inputs, counts hits toward stage and
// game completion, queues miss penalties and stretches each one over a full
// timer tick, and turns timer expiry into the FAIL state.
// Optional feature macro: GAME_PAUSE_EN enables the PAUSE state and pause_btn.
module game_sequencer #(
    parameter int TICK_DIV       = 5001,
    parameter int HITS_PER_STAGE = 8,
    parameter int NUM_STAGES     = 4,
    parameter int MISS_QMAX      = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       hit,
    input  logic       wrong,
    input  logic       timer_fail,
    output logic       timer_start,
    output logic       timer_miss,
    output logic       timer_clr,
    output logic [2:0] state,
    output logic [3:0] stage,
    output logic [3:0] hits
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_FAIL  = 3'd4,
        ST_CLEAR = 3'd5
    } state_t;

    localparam int             CNT_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TICK_DIV - 1);
    localparam logic [3:0]     LAST_HIT   = 4'(HITS_PER_STAGE - 1);
    localparam logic [3:0]     LAST_STAGE = 4'(NUM_STAGES - 1);
    localparam logic [2:0]     QMAX       = 3'(MISS_QMAX);

    state_t           cur_state;
    state_t           next_state;
    logic             start_prev;
    logic             start_edge;
    logic             pause_edge;
    logic             run_keep;
    logic             hit_ok;
    logic             wrong_ok;
    logic             stage_done;
    logic             game_done;
    logic [2:0]       miss_queue;
    logic [2:0]       queue_mid;
    logic [2:0]       queue_next;
    logic             dequeue;
    logic             flush;
    logic [CNT_W-1:0] stretch_cnt;

    assign state = cur_state;

    // Start-button edge detector; a held button starts only one game.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_prev <= 1'b0;
        end else begin
            start_prev <= start_btn;
        end
    end

    assign start_edge = start_btn & ~start_prev;

`ifdef GAME_PAUSE_EN
    logic pause_prev;

    // Pause-button edge detector; each press toggles RUN/PAUSE once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pause_prev <= 1'b0;
        end else begin
            pause_prev <= pause_btn;
        end
    end

    assign pause_edge = pause_btn & ~pause_prev;
`else
    logic unused_pause;
    assign unused_pause = pause_btn;
    assign pause_edge   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            cur_state <= next_state;
        end
    end

    // Next-state decode and qualified hit/wrong events (fail > pause > hit).
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        next_state = cur_state;
        run_keep   = (cur_state == ST_RUN) && !timer_fail && !pause_edge;
        hit_ok     = run_keep && hit;
        wrong_ok   = run_keep && wrong;
        stage_done = hit_ok && (hits == LAST_HIT);
        game_done  = stage_done && (stage == LAST_STAGE);
        case (cur_state)
            ST_IDLE:  if (start_edge) next_state = ST_ARM;
            ST_ARM:   next_state = ST_RUN;
            ST_RUN: begin
                if (timer_fail)      next_state = ST_FAIL;
                else if (pause_edge) next_state = ST_PAUSE;
                else if (game_done)  next_state = ST_CLEAR;
            end
`ifdef GAME_PAUSE_EN
            ST_PAUSE: if (pause_edge) next_state = ST_RUN;
`endif
            ST_FAIL, ST_CLEAR: if (start_edge) next_state = ST_ARM;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Timer control outputs, registered from the state being entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_start <= 1'b0;
            timer_clr   <= 1'b0;
        end else begin
            timer_start <= (next_state == ST_RUN);
            timer_clr   <= (next_state == ST_ARM);
        end
    end

    // Hit and stage counters; cleared on entry to ARM, held for display.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hits  <= 4'd0;
            stage <= 4'd0;
        end else if (next_state == ST_ARM) begin
            hits  <= 4'd0;
            stage <= 4'd0;
        end else if (stage_done) begin
            hits <= 4'd0;
            if (!game_done) stage <= stage + 4'd1;
        end else if (hit_ok) begin
            hits <= hits + 4'd1;
        end
    end

    // Miss queue arithmetic: dequeue into an idle stretcher, then enqueue
    // with saturation. Both are inactive outside RUN, so PAUSE freezes it.
    always_comb begin
        flush      = (next_state != ST_RUN) && (next_state != ST_PAUSE);
        dequeue    = (cur_state == ST_RUN) && !timer_miss && (miss_queue != 3'd0);
        queue_mid  = miss_queue - {2'b00, dequeue};
        queue_next = (wrong_ok && (queue_mid < QMAX)) ? queue_mid + 3'd1 : queue_mid;
    end

    // Miss stretcher: holds timer_miss for TICK_DIV running cycles per
    // penalty, then low for at least one cycle so the timer sees each one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            miss_queue  <= 3'd0;
            timer_miss  <= 1'b0;
            stretch_cnt <= '0;
        end else if (flush) begin
            miss_queue  <= 3'd0;
            timer_miss  <= 1'b0;
            stretch_cnt <= '0;
        end else begin
            miss_queue <= queue_next;
            if (cur_state == ST_RUN) begin
                if (timer_miss) begin
                    if (stretch_cnt == '0) timer_miss  <= 1'b0;
                    else                   stretch_cnt <= stretch_cnt - 1'b1;
                end else if (miss_queue != 3'd0) begin
                    timer_miss  <= 1'b1;
                    stretch_cnt <= CNT_LOAD;
                end
            end
        end
    end

endmodule
